// File: rtl/pool_pkg.sv
`default_nettype none
// ============================================================================
// pool_pkg : shared mode type and combine helpers for pool2d_stream | rev 1.0
// ============================================================================
package pool_pkg;

  typedef enum logic {POOL_MAX = 1'b0, POOL_AVG = 1'b1} pool_mode_e;

  // Combine operands are carried at this width; callers sign-extend in and truncate out.
  localparam int POOL_ACC_MAX_W = 32;

  function automatic int acc_w(input int data_w, input int k);
    return data_w + 2 * $clog2(k);
  endfunction

  function automatic logic signed [POOL_ACC_MAX_W-1:0] pool_combine(
    input pool_mode_e                        mode,
    input logic signed [POOL_ACC_MAX_W-1:0]  a,
    input logic signed [POOL_ACC_MAX_W-1:0]  b
  );
    if (mode == POOL_AVG) return a + b;
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pool_row_buf.sv
`default_nettype none
// ============================================================================
// pool_row_buf : per-channel partial-window row buffer, sync write / async read | rev 1.0
// ============================================================================
module pool_row_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int W     = 20
) (
  input  logic                clk,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic signed [W-1:0] wdata,
  input  logic [AW-1:0]       raddr,
  output logic signed [W-1:0] rdata
);

  logic signed [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule
`default_nettype wire

// File: rtl/pool2d_stream.sv
`default_nettype none
// ============================================================================
// pool2d_stream : streaming KxK stride-K MAX/AVG pooling, CH channels in lockstep | rev 1.0
// ============================================================================
module pool2d_stream
  import pool_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CH     = 4,
  parameter int K      = 2,
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 mode,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CH*DATA_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CH*DATA_W-1:0] out_data,
  output logic                 out_last
);

  localparam int LOG2K = $clog2(K);
  localparam int SHIFT = 2 * LOG2K;
  localparam int ACC_W = acc_w(DATA_W, K);
  localparam int NE    = IMG_W / K;
  localparam int AW    = (NE > 1) ? $clog2(NE) : 1;
  localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  generate
    if (K != 2 && K != 4) begin : g_bad_k
      $error("pool2d_stream: K must be 2 or 4");
    end
    if ((IMG_W % K) != 0 || (IMG_H % K) != 0) begin : g_bad_dim
      $error("pool2d_stream: IMG_W and IMG_H must be multiples of K");
    end
    if (ACC_W > POOL_ACC_MAX_W) begin : g_bad_acc
      $error("pool2d_stream: accumulator wider than pool_combine operands");
    end
  endgenerate

  logic [CW-1:0]        col_q, col_d;
  logic [RW-1:0]        row_q, row_d;
  pool_mode_e           mode_q, w_mode;
  logic                 out_valid_q, out_last_q;
  logic [CH*DATA_W-1:0] out_data_q, out_data_d;
  logic                 w_acc, w_first, w_hfirst, w_hlast, w_vfirst, w_vlast, w_emit, w_lastpix;
  logic [AW-1:0]        w_cidx;

  assign in_ready  = !out_valid_q || out_ready;
  assign w_acc     = in_valid && in_ready;
  assign w_hfirst  = (col_q[LOG2K-1:0] == '0);
  assign w_hlast   = (col_q[LOG2K-1:0] == LOG2K'(K-1));
  assign w_vfirst  = (row_q[LOG2K-1:0] == '0);
  assign w_vlast   = (row_q[LOG2K-1:0] == LOG2K'(K-1));
  assign w_emit    = w_hlast && w_vlast;
  assign w_first   = (col_q == '0) && (row_q == '0);
  assign w_lastpix = (col_q == CW'(IMG_W-1)) && (row_q == RW'(IMG_H-1));
  assign w_cidx    = AW'(col_q >> LOG2K);
  // The frame's first beat already pools with the live mode input.
  assign w_mode    = w_first ? pool_mode_e'(mode) : mode_q;

  always_comb begin
    col_d = col_q + CW'(1);
    row_d = row_q;
    if (col_q == CW'(IMG_W-1)) begin
      col_d = '0;
      row_d = (row_q == RW'(IMG_H-1)) ? '0 : row_q + RW'(1);
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic signed [ACC_W-1:0] w_samp, w_hcomb, w_rd, w_vcomb, hacc_q;

    assign w_samp  = ACC_W'(signed'(in_data[c*DATA_W +: DATA_W]));
    assign w_hcomb = w_hfirst ? w_samp
                   : ACC_W'(pool_combine(w_mode, POOL_ACC_MAX_W'(hacc_q), POOL_ACC_MAX_W'(w_samp)));
    assign w_vcomb = w_vfirst ? w_hcomb
                   : ACC_W'(pool_combine(w_mode, POOL_ACC_MAX_W'(w_rd), POOL_ACC_MAX_W'(w_hcomb)));
    assign out_data_d[c*DATA_W +: DATA_W] = (w_mode == POOL_AVG) ? DATA_W'(w_vcomb >>> SHIFT)
                                                                 : DATA_W'(w_vcomb);

    always_ff @(posedge clk) begin
      if (w_acc) hacc_q <= w_hcomb;
    end

    pool_row_buf #(
      .DEPTH (NE),
      .AW    (AW),
      .W     (ACC_W)
    ) u_row_buf (
      .clk   (clk),
      .we    (w_acc && w_hlast),
      .waddr (w_cidx),
      .wdata (w_vcomb),
      .raddr (w_cidx),
      .rdata (w_rd)
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      mode_q      <= POOL_MAX;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else if (clr) begin
      col_q       <= '0;
      row_q       <= '0;
      mode_q      <= POOL_MAX;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      if (w_acc) begin
        col_q <= col_d;
        row_q <= row_d;
        if (w_first) mode_q <= pool_mode_e'(mode);
      end
      // A completing beat can only be accepted when the register is free or draining.
      if (w_acc && w_emit) begin
        out_valid_q <= 1'b1;
        out_data_q  <= out_data_d;
        out_last_q  <= w_lastpix;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule
`default_nettype wire

// File: tb/tb_pool2d_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_pool2d_stream : scoreboard bench, directed 4x4 K=2 cases plus random 16x16 K=4 | rev 1.0
// ============================================================================
module tb_pool2d_stream;

  localparam int DW  = 16;
  localparam int CHB = 4;
  localparam int CKW = CHB*DW + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic rst_n;
  logic clr_a, mode_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a, out_last_a;
  logic [DW-1:0] in_data_a, out_data_a;
  logic clr_b, mode_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_last_b;
  logic [CHB*DW-1:0] in_data_b, out_data_b;

  logic [DW:0]     q_a [$];
  logic [CHB*DW:0] q_b [$];

  logic [DW-1:0] ramp [16];
  logic [DW-1:0] smax [16];
  logic [DW-1:0] savg [16];
  logic [DW-1:0] pb   [256][CHB];

  pool2d_stream #(.DATA_W(DW), .CH(1), .K(2), .IMG_W(4), .IMG_H(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr_a), .mode(mode_a),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a), .out_last(out_last_a)
  );

  pool2d_stream #(.DATA_W(DW), .CH(CHB), .K(4), .IMG_W(16), .IMG_H(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr_b), .mode(mode_b),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b), .out_last(out_last_b)
  );

  task automatic chk(input string name, input logic [CKW-1:0] act, input logic [CKW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
  endtask

  // Scoreboard monitors: a pooled beat transfers when valid && ready at the rising edge.
  initial forever begin
    @(negedge clk);
    if (rst_n && out_valid_a && out_ready_a) begin
      if (q_a.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL out_a_extra: got %0h, expected no output", {out_last_a, out_data_a});
      end else begin
        chk("out_a", CKW'({out_last_a, out_data_a}), CKW'(q_a.pop_front()));
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && out_valid_b && out_ready_b) begin
      if (q_b.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL out_b_extra: got %0h, expected no output", {out_last_b, out_data_b});
      end else begin
        chk("out_b", CKW'({out_last_b, out_data_b}), CKW'(q_b.pop_front()));
      end
    end
  end

  initial begin
    out_ready_b = 1'b0;
    forever begin
      @(posedge clk); #1;
      out_ready_b = ($urandom_range(0, 9) < 7);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push4_a(input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                         input logic [DW-1:0] e2, input logic [DW-1:0] e3);
    q_a.push_back({1'b0, e0});
    q_a.push_back({1'b0, e1});
    q_a.push_back({1'b0, e2});
    q_a.push_back({1'b1, e3});
  endtask

  // Present one beat on A; returns 1 ns after the accepting edge.
  task automatic send_a(input logic [DW-1:0] d, input bit completes);
    int guard;
    guard = 0;
    in_valid_a = 1'b1;
    in_data_a  = d;
    forever begin
      @(negedge clk);
      if (in_ready_a) break;
      guard++;
      if (guard > 1000) begin timeout("in_handshake_a"); break; end
    end
    @(posedge clk); #1;
    if (completes) chk("latency_a", CKW'(out_valid_a), CKW'(1'b1));
  endtask

  task automatic send_frame_a(input logic [DW-1:0] px [16], input bit m, input int toggle_at, input int n);
    for (int i = 0; i < n; i++) begin
      if (i == 0) mode_a = m;
      else if (i == toggle_at) mode_a = ~m;
      send_a(px[i], ((i % 4) % 2 == 1) && ((i / 4) % 2 == 1));
    end
    in_valid_a = 1'b0;
  endtask

  task automatic model_b(input bit m);
    for (int wy = 0; wy < 4; wy++) begin
      for (int wx = 0; wx < 4; wx++) begin
        logic [CHB*DW-1:0] e;
        e = '0;
        for (int c = 0; c < CHB; c++) begin
          int acc;
          int v;
          acc = 0;
          for (int dy = 0; dy < 4; dy++) begin
            for (int dx = 0; dx < 4; dx++) begin
              v = int'($signed(pb[(wy*4 + dy)*16 + wx*4 + dx][c]));
              if (dy == 0 && dx == 0) acc = v;
              else if (m) acc = acc + v;
              else if (v > acc) acc = v;
            end
          end
          if (m) acc = acc >>> 4;
          e[c*DW +: DW] = acc[DW-1:0];
        end
        q_b.push_back({(wy == 3 && wx == 3), e});
      end
    end
  endtask

  task automatic drive_b(input bit m);
    for (int i = 0; i < 256; i++) begin
      int gap;
      int guard;
      gap = $urandom_range(0, 2);
      if (gap != 0) begin
        in_valid_b = 1'b0;
        idle(gap);
      end
      if (i == 0) mode_b = m;
      else if (i == 100) mode_b = ~m;
      for (int c = 0; c < CHB; c++) in_data_b[c*DW +: DW] = pb[i][c];
      in_valid_b = 1'b1;
      guard = 0;
      forever begin
        @(negedge clk);
        if (in_ready_b) break;
        guard++;
        if (guard > 1000) begin timeout("in_handshake_b"); break; end
      end
      @(posedge clk); #1;
    end
    in_valid_b = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] held;
    int g;
    rst_n = 1'b0;
    clr_a = 1'b0; mode_a = 1'b0; in_valid_a = 1'b0; in_data_a = '0; out_ready_a = 1'b1;
    clr_b = 1'b0; mode_b = 1'b0; in_valid_b = 1'b0; in_data_b = '0;
    for (int i = 0; i < 16; i++) ramp[i] = DW'(i);
    smax = '{16'hFFF8, 16'hFFFB, 16'h0003, 16'hFFFC, 16'hFFF9, 16'hFFFA, 16'h0064, 16'h8000,
             16'h8000, 16'h8000, 16'h0007, 16'h0007, 16'h8000, 16'h8000, 16'h0007, 16'h0007};
    savg = '{16'hFFFF, 16'hFFFE, 16'h7FFF, 16'h7FFF, 16'hFFFD, 16'hFFFD, 16'h7FFF, 16'h7FFF,
             16'h8000, 16'h8000, 16'h0001, 16'h0001, 16'h8000, 16'h8000, 16'h0001, 16'h0000};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", CKW'(out_valid_a), CKW'(1'b0));
    chk("rst_out_data",  CKW'(out_data_a),  CKW'(0));
    chk("rst_out_last",  CKW'(out_last_a),  CKW'(1'b0));
    chk("rst_in_ready",  CKW'(in_ready_a),  CKW'(1'b1));
    chk("rst_out_valid_b", CKW'(out_valid_b), CKW'(1'b0));
    rst_n = 1'b1;
    idle(2);

    // Ramp frame, MAX then AVG
    push4_a(16'd5, 16'd7, 16'd13, 16'd15);
    send_frame_a(ramp, 1'b0, -1, 16);
    push4_a(16'd2, 16'd4, 16'd10, 16'd12);
    send_frame_a(ramp, 1'b1, -1, 16);

    // Signed windows
    push4_a(16'hFFFB, 16'h0064, 16'h8000, 16'h0007);
    send_frame_a(smax, 1'b0, -1, 16);
    push4_a(16'hFFFD, 16'h7FFF, 16'h8000, 16'h0000);
    send_frame_a(savg, 1'b1, -1, 16);
    idle(3);

    // Backpressure: hold the first pooled beat for 5 cycles
    push4_a(16'd5, 16'd7, 16'd13, 16'd15);
    fork
      send_frame_a(ramp, 1'b0, -1, 16);
      begin
        g = 0;
        do begin @(posedge clk); #1; g++; end while (!out_valid_a && g < 100);
        if (g >= 100) timeout("bp_wait_valid");
        out_ready_a = 1'b0;
        held = out_data_a;
        repeat (5) begin
          @(negedge clk);
          chk("bp_in_ready",  CKW'(in_ready_a),  CKW'(1'b0));
          chk("bp_out_valid", CKW'(out_valid_a), CKW'(1'b1));
          chk("bp_out_hold",  CKW'(out_data_a),  CKW'(held));
        end
        @(posedge clk); #1;
        out_ready_a = 1'b1;
      end
    join
    idle(3);

    // Asynchronous reset after 6 beats drops the pending output and the partial frame
    send_frame_a(ramp, 1'b0, -1, 6);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", CKW'(out_valid_a), CKW'(1'b0));
    chk("mid_rst_out_data",  CKW'(out_data_a),  CKW'(0));
    chk("mid_rst_out_last",  CKW'(out_last_a),  CKW'(1'b0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    push4_a(16'd2, 16'd4, 16'd10, 16'd12);
    send_frame_a(ramp, 1'b1, -1, 16);
    idle(3);

    // Soft clear after 6 beats with the pending output not yet taken
    send_frame_a(ramp, 1'b0, -1, 6);
    out_ready_a = 1'b0;
    clr_a = 1'b1;
    @(posedge clk); #1;
    clr_a = 1'b0;
    chk("clr_out_valid", CKW'(out_valid_a), CKW'(1'b0));
    chk("clr_out_data",  CKW'(out_data_a),  CKW'(0));
    chk("clr_out_last",  CKW'(out_last_a),  CKW'(1'b0));
    out_ready_a = 1'b1;
    idle(1);
    push4_a(16'd2, 16'd4, 16'd10, 16'd12);
    send_frame_a(ramp, 1'b1, -1, 16);
    idle(3);

    // Mode toggled mid-frame takes effect only at the next frame
    push4_a(16'd5, 16'd7, 16'd13, 16'd15);
    send_frame_a(ramp, 1'b0, 3, 16);
    push4_a(16'd2, 16'd4, 16'd10, 16'd12);
    send_frame_a(ramp, 1'b1, -1, 16);

    // Random 16x16 frames on the 4-channel K=4 instance
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 256; i++) begin
        for (int c = 0; c < CHB; c++) begin
          if ($urandom_range(0, 3) == 0) pb[i][c] = DW'($urandom);
          else pb[i][c] = DW'($urandom_range(0, 200)) - DW'(100);
        end
      end
      model_b(f == 1);
      drive_b(f == 1);
    end

    g = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && g < 2000) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 2000) timeout("scoreboard_drain");
    idle(5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
